// File: rtl/rv32_pkg.sv
// ============================================================================
// rv32_pkg : shared RV32 datapath constants, ALU opcodes, forwarding selects
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package rv32_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CTRL_W     = 4;

  localparam logic [CTRL_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_SLL  = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_SLT  = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_SLTU = 4'b0011;
  localparam logic [CTRL_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [CTRL_W-1:0] ALU_SRL  = 4'b0101;
  localparam logic [CTRL_W-1:0] ALU_OR   = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_AND  = 4'b0111;
  localparam logic [CTRL_W-1:0] ALU_SUB  = 4'b1000;
  localparam logic [CTRL_W-1:0] ALU_SRA  = 4'b1101;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

endpackage

`default_nettype wire

// File: rtl/id_ex_stage_fwd_mux.sv
// ============================================================================
// fwd_mux : per-operand forwarding select, EX/MEM over MEM/WB over regfile
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module fwd_mux
  import rv32_pkg::*;
#(
  parameter int XLEN_P       = 32,
  parameter int REG_ADDR_W_P = 5
) (
  input  logic [REG_ADDR_W_P-1:0] addr_i,
  input  logic [XLEN_P-1:0]       rf_data_i,
  input  logic [REG_ADDR_W_P-1:0] exmem_rd_i,
  input  logic                    exmem_we_i,
  input  logic [XLEN_P-1:0]       exmem_result_i,
  input  logic [REG_ADDR_W_P-1:0] memwb_rd_i,
  input  logic                    memwb_we_i,
  input  logic [XLEN_P-1:0]       memwb_result_i,
  output logic [XLEN_P-1:0]       data_o
);

  fwd_sel_e sel;
  logic     addr_nz;

  assign addr_nz = (addr_i != '0);

  always_comb begin
    sel = FWD_RF;
    if (exmem_we_i && (exmem_rd_i == addr_i) && addr_nz) begin
      sel = FWD_EXMEM;
    end else if (memwb_we_i && (memwb_rd_i == addr_i) && addr_nz) begin
      sel = FWD_MEMWB;
    end
  end

  always_comb begin
    data_o = rf_data_i;
    case (sel)
      FWD_EXMEM: data_o = exmem_result_i;
      FWD_MEMWB: data_o = memwb_result_i;
      default:   data_o = rf_data_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// id_ex_stage : ID/EX register with operand forwarding and ALU source select
// Optional macro ID_EX_STALL_CNT_EN adds saturating stall/flush counters.
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module id_ex_stage
  import rv32_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CTRL_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [XLEN-1:0]       in_rs1_data,
  input  logic [XLEN-1:0]       in_rs2_data,
  input  logic [XLEN-1:0]       in_imm,
  input  logic [REG_ADDR_W-1:0] in_rs1_addr,
  input  logic [REG_ADDR_W-1:0] in_rs2_addr,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_reg_write,
  input  logic                  in_src_a_pc,
  input  logic                  in_src_b_imm,
  input  logic [CTRL_W-1:0]     in_alu_ctrl,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic                  exmem_reg_write,
  input  logic                  memwb_reg_write,
  input  logic [XLEN-1:0]       exmem_result,
  input  logic [XLEN-1:0]       memwb_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       alu_input_a,
  output logic [XLEN-1:0]       alu_input_b,
  output logic [CTRL_W-1:0]     alu_ctrl,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_reg_write,
  output logic [XLEN-1:0]       out_store_data
`ifdef ID_EX_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt
`endif
);

  logic [XLEN-1:0]       fwd_rs1, fwd_rs2;
  logic                  capture;
  logic                  valid_q, valid_d;
  logic                  reg_write_q, reg_write_d;
  logic [XLEN-1:0]       a_q, b_q, store_q;
  logic [CTRL_W-1:0]     ctrl_q;
  logic [REG_ADDR_W-1:0] rd_q;

  fwd_mux #(.XLEN_P(XLEN), .REG_ADDR_W_P(REG_ADDR_W)) u_fwd_rs1 (
    .addr_i         (in_rs1_addr),
    .rf_data_i      (in_rs1_data),
    .exmem_rd_i     (exmem_rd),
    .exmem_we_i     (exmem_reg_write),
    .exmem_result_i (exmem_result),
    .memwb_rd_i     (memwb_rd),
    .memwb_we_i     (memwb_reg_write),
    .memwb_result_i (memwb_result),
    .data_o         (fwd_rs1)
  );

  fwd_mux #(.XLEN_P(XLEN), .REG_ADDR_W_P(REG_ADDR_W)) u_fwd_rs2 (
    .addr_i         (in_rs2_addr),
    .rf_data_i      (in_rs2_data),
    .exmem_rd_i     (exmem_rd),
    .exmem_we_i     (exmem_reg_write),
    .exmem_result_i (exmem_result),
    .memwb_rd_i     (memwb_rd),
    .memwb_we_i     (memwb_reg_write),
    .memwb_result_i (memwb_result),
    .data_o         (fwd_rs2)
  );

  assign in_ready = !valid_q || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  always_comb begin
    valid_d     = valid_q;
    reg_write_d = reg_write_q;
    if (flush) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
    end else if (capture) begin
      valid_d     = 1'b1;
      reg_write_d = in_reg_write;
    end else if (out_ready) begin
      valid_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
    end
  end

  // Operands are stored already resolved; a held instruction keeps them as-is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      store_q <= '0;
      ctrl_q  <= ALU_ADD;
      rd_q    <= '0;
    end else if (capture) begin
      a_q     <= in_src_a_pc  ? in_pc  : fwd_rs1;
      b_q     <= in_src_b_imm ? in_imm : fwd_rs2;
      store_q <= fwd_rs2;
      ctrl_q  <= in_alu_ctrl;
      rd_q    <= in_rd;
    end
  end

  assign out_valid      = valid_q;
  assign out_reg_write  = reg_write_q;
  assign alu_input_a    = a_q;
  assign alu_input_b    = b_q;
  assign out_store_data = store_q;
  assign alu_ctrl       = ctrl_q;
  assign out_rd         = rd_q;

`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;
  logic        stall_evt, flush_evt;

  assign stall_evt = valid_q && !out_ready;
  assign flush_evt = flush && (valid_q || (in_valid && in_ready));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_evt && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_evt && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

`default_nettype wire
